// File: rtl/mipi_rx_pkg.sv
// rtl/mipi_rx_pkg.sv - shared constants, state encoding and sizing helper for the MIPI RX frame assembler
package mipi_rx_pkg;

  localparam int WORD_BYTES = 6;
  localparam logic [8*WORD_BYTES-1:0] SYNC_WORD = 48'h7E7E_7E7E_7E7E;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2,
    HOLD    = 2'd3
  } state_t;

  function automatic int calc_nwords(input int dlen);
    return (dlen + WORD_BYTES - 1) / WORD_BYTES;
  endfunction

endpackage

// File: rtl/mipi_rx_frame_assembler.sv
// rtl/mipi_rx_frame_assembler.sv - hunts SYNC, collects a DLEN-byte payload with XOR trailer, hands it off valid/ready
module mipi_rx_frame_assembler
  import mipi_rx_pkg::*;
#(
  parameter int DLEN = 80
) (
  input  logic                rx_pixel_clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [47:0]         in_data,
  input  logic                in_vsync,
  output logic [DLEN*8-1:0]   data,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                chk_err,
  output logic [7:0]          drop_cnt,
  output logic [7:0]          err_cnt
);

  localparam int NWORDS = calc_nwords(DLEN);
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [47:0]         acc_q, acc_d;
  logic [DLEN*8-1:0]   shadow_q, shadow_d;
  logic [DLEN*8-1:0]   data_d;
  logic                data_valid_d;
  logic                chk_err_d;
  logic [7:0]          drop_cnt_d, err_cnt_d;
  logic                vsync_q;
  logic                vsync_rise;

  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      acc_q      <= '0;
      shadow_q   <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      chk_err    <= 1'b0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      shadow_q   <= shadow_d;
      data       <= data_d;
      data_valid <= data_valid_d;
      chk_err    <= chk_err_d;
      drop_cnt   <= drop_cnt_d;
      err_cnt    <= err_cnt_d;
      vsync_q    <= in_vsync;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    shadow_d     = shadow_q;
    data_d       = data;
    data_valid_d = data_valid;
    chk_err_d    = 1'b0;
    drop_cnt_d   = drop_cnt;
    err_cnt_d    = err_cnt;
    vsync_rise   = in_vsync & ~vsync_q;

    // A VSYNC edge mid-frame wins over any word arriving in the same cycle.
    if (vsync_rise && (state_q == PAYLOAD || state_q == TRAILER)) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT: begin
          if (in_valid && in_data == SYNC_WORD) begin
            state_d  = PAYLOAD;
            cnt_d    = '0;
            acc_d    = '0;
            shadow_d = '0;
          end
        end
        PAYLOAD: begin
          if (in_valid) begin
            acc_d = acc_q ^ in_data;
            // Only bytes below DLEN have a shadow slot; the tail of the last word only feeds the XOR.
            for (int b = 0; b < DLEN; b++) begin
              if (cnt_q == CW'(b / WORD_BYTES))
                shadow_d[8*b +: 8] = in_data[8*(b % WORD_BYTES) +: 8];
            end
            if (cnt_q == CW'(NWORDS - 1))
              state_d = TRAILER;
            else
              cnt_d = cnt_q + 1'b1;
          end
        end
        TRAILER: begin
          if (in_valid) begin
            if (in_data == acc_q) begin
              data_d       = shadow_q;
              data_valid_d = 1'b1;
              state_d      = HOLD;
            end else begin
              chk_err_d = 1'b1;
              if (err_cnt != 8'hFF)
                err_cnt_d = err_cnt + 8'd1;
              state_d = HUNT;
            end
          end
        end
        HOLD: begin
          if (in_valid && in_data == SYNC_WORD && drop_cnt != 8'hFF)
            drop_cnt_d = drop_cnt + 8'd1;
          if (data_valid && data_ready) begin
            data_valid_d = 1'b0;
            state_d      = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_rx_frame_assembler.sv
// tb/tb_mipi_rx_frame_assembler.sv - randomized self-checking bench for mipi_rx_frame_assembler
module tb_mipi_rx_frame_assembler;

  localparam int DLEN = 80;
  localparam int NW   = 14;
  localparam logic [47:0] SYNC = 48'h7E7E_7E7E_7E7E;

  logic              rx_pixel_clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [47:0]       in_data = '0;
  logic              in_vsync = 1'b0;
  logic              data_ready = 1'b1;
  logic [DLEN*8-1:0] data;
  logic              data_valid;
  logic              chk_err;
  logic [7:0]        drop_cnt;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [47:0]       words [NW];
  logic [DLEN*8-1:0] exp_data = '0;
  int                exp_err  = 0;
  int                exp_drop = 0;

  int   dv_rises   = 0;
  int   chk_pulses = 0;
  logic dv_prev    = 1'b0;

  mipi_rx_frame_assembler #(.DLEN(DLEN)) dut (
    .rx_pixel_clk (rx_pixel_clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_vsync     (in_vsync),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .chk_err      (chk_err),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 rx_pixel_clk = ~rx_pixel_clk;

  always @(negedge rx_pixel_clk) begin
    if (data_valid === 1'b1 && dv_prev !== 1'b1) dv_rises++;
    if (chk_err === 1'b1) chk_pulses++;
    dv_prev = data_valid;
  end

  task automatic check(input string tag, input logic [DLEN*8-1:0] got, input logic [DLEN*8-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge rx_pixel_clk);
    #1;
  endtask

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = rand48();
      step();
    end
  endtask

  task automatic send(input logic [47:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
    in_data  = rand48();
  endtask

  function automatic logic [DLEN*8-1:0] payload_of();
    byte unsigned q[$];
    logic [DLEN*8-1:0] r;
    logic [47:0] w;
    for (int k = 0; k < NW; k++) begin
      w = words[k];
      for (int j = 0; j < 6; j++) q.push_back(w[8*j +: 8]);
    end
    r = '0;
    for (int i = 0; i < DLEN; i++) r[8*i +: 8] = q[i];
    return r;
  endfunction

  function automatic logic [47:0] xor_of();
    logic [47:0] x = '0;
    foreach (words[k]) x ^= words[k];
    return x;
  endfunction

  task automatic fill_k();
    for (int k = 0; k < NW; k++) words[k] = {6{8'(k)}};
  endtask

  task automatic fill_rand();
    for (int k = 0; k < NW; k++) begin
      words[k] = rand48();
      if (words[k] == SYNC) words[k] = ~words[k];
    end
  endtask

  task automatic send_frame(input int gap, input bit bad);
    send(SYNC);
    idle(gap);
    for (int k = 0; k < NW; k++) begin
      send(words[k]);
      idle(gap);
    end
    check("dv_before_trailer", data_valid, 0);
    send(xor_of() ^ {47'd0, bad});
    if (!bad) begin
      exp_data = payload_of();
      check("dv_after_trailer", data_valid, 1);
      check("payload", data, exp_data);
      check("chk_err_good", chk_err, 0);
    end else begin
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      check("chk_err_bad", chk_err, 1);
      check("dv_bad", data_valid, 0);
      check("data_kept", data, exp_data);
      check("err_cnt", err_cnt, exp_err);
    end
  endtask

  initial begin
    int c0, d0;
    logic stable;
    logic [DLEN*8-1:0] snap;

    step();
    step();
    check("rst_dv", data_valid, 0);
    check("rst_data", data, 0);
    check("rst_chk", chk_err, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_err", err_cnt, 0);
    rst = 1'b0;
    idle(2);

    // clean frame with k-pattern
    fill_k();
    data_ready = 1'b1;
    send_frame(0, 0);
    check("byte79", data[8*79 +: 8], 13);
    step();
    check("dv_one_cycle", data_valid, 0);
    check("dv_rises_clean", dv_rises, 1);

    // bad trailer
    c0 = chk_pulses;
    send_frame(0, 1);
    step();
    check("chk_err_one_cycle", chk_err, 0);
    check("chk_pulse_count", chk_pulses - c0, 1);
    check("no_dv_on_bad", dv_rises, 1);

    // blanking and backpressure
    fill_rand();
    data_ready = 1'b0;
    send_frame(3, 0);
    snap = data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 12) send(SYNC);
      else idle(1);
      if (data !== snap || data_valid !== 1'b1) stable = 1'b0;
    end
    exp_drop += 2;
    check("hold_stable", stable, 1);
    check("drop_cnt", drop_cnt, exp_drop);
    data_ready = 1'b1;
    step();
    check("dv_after_handshake", data_valid, 0);
    check("data_after_handshake", data, exp_data);
    idle(1);

    // vsync abort mid-payload
    fill_rand();
    send(SYNC);
    for (int k = 0; k < 7; k++) send(words[k]);
    in_vsync = 1'b1;
    idle(2);
    in_vsync = 1'b0;
    idle(1);
    c0 = chk_pulses;
    d0 = dv_rises;
    fill_rand();
    send_frame(1, 0);
    step();
    check("vsync_no_chk", chk_pulses - c0, 0);
    check("vsync_one_dv", dv_rises - d0, 1);

    // SYNC-valued payload word
    fill_rand();
    words[3] = SYNC;
    send_frame(0, 0);
    check("embedded_sync", data[8*18 +: 48], SYNC);
    step();

    // randomized frames with random blanking and corruption
    for (int f = 0; f < 8; f++) begin
      fill_rand();
      send_frame($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      check("rand_err_cnt", err_cnt, exp_err);
      check("rand_drop_cnt", drop_cnt, exp_drop);
      step();
    end

    // reset while holding
    fill_k();
    data_ready = 1'b0;
    send_frame(0, 0);
    idle(2);
    check("hold_before_rst", data_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_hold_dv", data_valid, 0);
    check("rst_hold_data", data, 0);
    check("rst_hold_drop", drop_cnt, 0);
    check("rst_hold_err", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
